reg_dump: RTL

- Debug read-out engine for the 8-bit register bank.
- On a start request it walks every register address on a bank read port and captures each value.
- Each captured value is presented as one beat on a valid/ready byte stream (address-tagged, last-flagged) toward the debug/serial link.
- It is the consumer/reader counterpart of the bank's write port: it never writes the bank, only sequences reads.

---
 rtl/redux_pkg.sv | 15 +
 rtl/reg_dump.sv | 98 +++++++++
 2 files changed

// File: rtl/redux_pkg.sv
// Constants shared between the register bank and its debug read-out engine,
// plus the dump sequencer state encoding.
package redux_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned NUM_REGS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } dump_state_t;

endpackage

// File: rtl/reg_dump.sv
// Register-bank dump engine: walks addresses 0..NUM_REGS-1 on a bank read
// port and emits each captured value as an address-tagged valid/ready beat.
module reg_dump
  import redux_pkg::*;
#(
  parameter int unsigned DATA_W   = redux_pkg::DATA_W,
  parameter int unsigned ADDR_W   = redux_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = redux_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  dump_state_t       state, state_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic              out_valid_nxt;
  logic [DATA_W-1:0] out_data_nxt;
  logic [ADDR_W-1:0] out_addr_nxt;
  logic              out_last_nxt;
  logic              done_nxt;

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_addr   <= rd_addr_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_addr  <= out_addr_nxt;
      out_last  <= out_last_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state and next-output decode; beat fields hold unless updated
  always_comb begin
    state_nxt     = state;
    rd_addr_nxt   = rd_addr;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_addr_nxt  = out_addr;
    out_last_nxt  = out_last;
    done_nxt      = 1'b0;

    unique case (state)
      IDLE: begin
        rd_addr_nxt = '0;
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        out_data_nxt  = rd_data;
        out_addr_nxt  = rd_addr;
        out_last_nxt  = (rd_addr == LAST_ADDR);
        out_valid_nxt = 1'b1;
        state_nxt     = SEND;
      end
      SEND: begin
        if (out_valid && out_ready) begin
          out_valid_nxt = 1'b0;
          if (out_last) begin
            rd_addr_nxt = '0;
            done_nxt    = 1'b1;
            state_nxt   = IDLE;
          end else begin
            rd_addr_nxt = rd_addr + ADDR_W'(1);
            state_nxt   = FETCH;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule
